vga_frame_monitor: RTL and testbench

Passive sink for the game's VGA output. It samples `hor_sync`, `ver_sync` and the 24-bit RGB bus on each pixel strobe, checks them against 640x480@60 timing, and locks onto the frame. Once locked it reports the pixel coordinate and colour of every active pixel, and captures one probe pixel per frame. It sits beside the VGA controller as the receiving end of that interface, for on-chip self-check and for bench scoreboarding.

---
 rtl/vga_frame_monitor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: passive VGA sink that locks on 640x480@60 timing and reports pixels.
// Define VGA_MON_CRC_EN to add a per-frame CRC-16-CCITT of the active pixels.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hor_sync,
    input  logic        ver_sync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic [23:0] probe_rgb,
    output logic        probe_valid,
    output logic        frame_done,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic [15:0] frame_crc
);

    localparam logic [10:0] HT_C   = 11'(H_TOTAL);
    localparam logic [10:0] HT_M1  = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_C   = 11'(H_SYNC);
    localparam logic [10:0] H_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  VT_M1  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_C   = 10'(V_SYNC);
    localparam logic [9:0]  V_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       arst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign arst_n = rst_sync[1];

    state_t      state_q;
    state_t      state_d;
    logic        hs_q;
    logic        vs_q;
    logic [10:0] hcnt_q;
    logic [10:0] hcnt_d;
    logic [10:0] hcnt_inc;
    logic [9:0]  vcnt_q;
    logic [9:0]  vcnt_d;
    logic [9:0]  probe_xq;
    logic [9:0]  probe_yq;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic [23:0] rgb;

    logic hs_fall;
    logic hs_rise;
    logic vs_fall;
    logic vs_rise;
    logic fault;
    logic in_win;
    logic pix_fire;
    logic probe_hit;
    logic done_d;
    logic err_d;

    assign rgb     = {red, green, blue};
    assign hs_fall = pix_en & hs_q & ~hor_sync;
    assign hs_rise = pix_en & ~hs_q & hor_sync;
    assign vs_fall = pix_en & vs_q & ~ver_sync;
    assign vs_rise = pix_en & ~vs_q & ver_sync;

    assign hcnt_inc = (hcnt_q == HT_C) ? hcnt_q : hcnt_q + 11'd1;
    assign hcnt_d   = hs_fall ? 11'd0 : hcnt_inc;

    always_comb begin
        vcnt_d = vcnt_q;
        if (vs_fall) begin
            vcnt_d = 10'd0;
        end else if (hs_fall) begin
            vcnt_d = vcnt_q + 10'd1;
        end
    end

    // Rise checks use the count of the sample that shows the rise.
    always_comb begin
        fault = 1'b0;
        if (hs_fall && hcnt_q != HT_M1) begin
            fault = 1'b1;
        end
        if (hs_rise && hcnt_d != HS_C) begin
            fault = 1'b1;
        end
        if (vs_fall && vcnt_q != VT_M1) begin
            fault = 1'b1;
        end
        if (vs_rise && vcnt_d != VS_C) begin
            fault = 1'b1;
        end
        if (pix_en && !hs_fall && hcnt_q == HT_M1) begin
            fault = 1'b1;
        end
    end

    assign in_win = (hcnt_d >= H_BEG) && (hcnt_d < H_END) &&
                    (vcnt_d >= V_BEG) && (vcnt_d < V_END);

    assign x_d = 10'(hcnt_d - H_BEG);
    assign y_d = vcnt_d - V_BEG;

    assign pix_fire  = pix_en && (state_q == LOCKED) && in_win;
    assign probe_hit = pix_fire && (x_d == probe_xq) && (y_d == probe_yq);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = TRAIN;
                end
            end
            TRAIN: begin
                if (fault) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (fault) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end else if (vs_fall) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Syncs idle high, so a low first sample counts as a fall.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hcnt_q   <= 11'd0;
            vcnt_q   <= 10'd0;
            probe_xq <= 10'd0;
            probe_yq <= 10'd0;
        end else if (pix_en) begin
            hs_q   <= hor_sync;
            vs_q   <= ver_sync;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (vs_fall) begin
                probe_xq <= probe_x;
                probe_yq <= probe_y;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 24'd0;
            probe_valid <= 1'b0;
            probe_rgb   <= 24'd0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            locked      <= (state_d == LOCKED);
            pix_valid   <= pix_fire;
            probe_valid <= probe_hit;
            frame_done  <= done_d;
            err_pulse   <= err_d;
            if (pix_fire) begin
                pix_x   <= x_d;
                pix_y   <= y_d;
                pix_rgb <= rgb;
            end
            if (probe_hit) begin
                probe_rgb <= rgb;
            end
            if (err_d && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_px(
        input logic [15:0] c_in,
        input logic [23:0] d
    );
        logic [15:0] c;
        c = c_in;
        for (int i = 2; i >= 0; i--) begin
            c = c ^ {d[i*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) begin
                if (c[15]) begin
                    c = {c[14:0], 1'b0} ^ 16'h1021;
                end else begin
                    c = {c[14:0], 1'b0};
                end
            end
        end
        return c;
    endfunction

    logic [15:0] crc_acc;

    // The fall that closes a frame also opens the next accumulation.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= 16'd0;
        end else if (pix_en) begin
            if (vs_fall) begin
                crc_acc <= 16'hFFFF;
            end else if (pix_fire) begin
                crc_acc <= crc_px(crc_acc, rgb);
            end
            if (done_d) begin
                frame_crc <= crc_acc;
            end
        end
    end
`else
    assign frame_crc = 16'd0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: table-driven frame bench for vga_frame_monitor.
// Uses a scaled-down raster so each frame is a few hundred clocks.
module tb_vga_frame_monitor;

    localparam int HA = 8;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = 10;
    localparam int XB = HS + HB;
    localparam int YB = VS + VB;

    localparam int M_CONST = 0;
    localparam int M_COORD = 1;
    localparam int M_ZERO  = 2;
    localparam int M_FLIP  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hor_sync = 1'b1;
    logic        ver_sync = 1'b1;
    logic [7:0]  red = 8'd0;
    logic [7:0]  green = 8'd0;
    logic [7:0]  blue = 8'd0;
    logic [9:0]  probe_x = 10'd0;
    logic [9:0]  probe_y = 10'd0;
    logic        locked;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic [23:0] probe_rgb;
    logic        probe_valid;
    logic        frame_done;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] frame_crc;

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hor_sync(hor_sync), .ver_sync(ver_sync),
        .red(red), .green(green), .blue(blue),
        .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid),
        .frame_done(frame_done), .err_pulse(err_pulse),
        .err_count(err_count), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pattern(input int mode, input int x,
                                            input int y);
        logic [23:0] r;
        case (mode)
            M_CONST: r = 24'h123456;
            M_COORD: r = {x[7:0], y[7:0], 8'h00};
            M_FLIP:  r = (x == 5 && y == 1) ? 24'h000001 : 24'h000000;
            default: r = 24'h000000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] golden(input int mode);
        logic [15:0] c;
        logic [23:0] d;
        logic fb;
        c = 16'hFFFF;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                d = pattern(mode, x, y);
                for (int b = 23; b >= 0; b--) begin
                    fb = c[15] ^ d[b];
                    c = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        end
        return c;
    endfunction

    int cur_mode = M_CONST;
    int n_pix = 0;
    int n_done = 0;
    int n_probe = 0;
    int n_err = 0;
    logic [19:0] log_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                n_pix++;
                log_q.push_back({pix_x, pix_y});
                check("pix_rgb", 32'(pix_rgb),
                      32'(pattern(cur_mode, int'(pix_x), int'(pix_y))));
            end
            if (frame_done) n_done++;
            if (probe_valid) n_probe++;
            if (err_pulse) n_err++;
        end
    end

    typedef struct {
        int mode;
        int px;
        int py;
        int ll;
        int sl;
        int e_pix;
        int e_done;
        int e_probe;
        int e_err;
        int e_lf;
        int e_le;
        int e_errc;
        int e_prgb;
        int chk_crc;
        int e_crc;
        int chk_xy;
        int pre_rst;
    } vec_t;

    vec_t tbl[18];

    task automatic strobe(input logic hs, input logic vs,
                          input logic [23:0] c);
        @(negedge clk);
        hor_sync = hs;
        ver_sync = vs;
        {red, green, blue} = c;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic check_zero(input string p);
        check({p, " flags"},
              {27'd0, locked, pix_valid, probe_valid, frame_done, err_pulse},
              32'd0);
        check({p, " pix_xy"}, {12'd0, pix_x, pix_y}, 32'd0);
        check({p, " pix_rgb"}, 32'(pix_rgb), 32'd0);
        check({p, " probe_rgb"}, 32'(probe_rgb), 32'd0);
        check({p, " err_count"}, 32'(err_count), 32'd0);
        check({p, " frame_crc"}, 32'(frame_crc), 32'd0);
    endtask

    task automatic midline_reset();
        for (int p = 0; p < 6; p++) begin
            strobe(p >= HS, 1'b0, 24'hABCDEF);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_rec(input int idx, input vec_t v);
        int b_pix, b_done, b_probe, b_err, base, len, hw, lf;
        logic [23:0] c;
        string n;
        n = $sformatf("r%0d", idx);
        if (v.pre_rst != 0) midline_reset();
        probe_x = 10'(v.px);
        probe_y = 10'(v.py);
        cur_mode = v.mode;
        b_pix = n_pix;
        b_done = n_done;
        b_probe = n_probe;
        b_err = n_err;
        base = log_q.size();
        lf = 0;
        for (int l = 0; l < VT; l++) begin
            len = (l == v.ll) ? HT + 1 : HT;
            hw = (l == v.sl) ? HS - 1 : HS;
            for (int p = 0; p < len; p++) begin
                if (p >= XB && p < XB + HA && l >= YB && l < YB + VA)
                    c = pattern(v.mode, p - XB, l - YB);
                else
                    c = 24'hABCDEF;
                strobe(p >= hw, l >= VS, c);
                if (l == 0 && p == 0) lf = int'(locked);
            end
        end
        #1;
        check({n, " pix_valid count"}, n_pix - b_pix, v.e_pix);
        check({n, " frame_done count"}, n_done - b_done, v.e_done);
        check({n, " probe_valid count"}, n_probe - b_probe, v.e_probe);
        check({n, " err_pulse count"}, n_err - b_err, v.e_err);
        check({n, " locked after vsync fall"}, lf, v.e_lf);
        check({n, " locked at end"}, 32'(locked), v.e_le);
        check({n, " err_count"}, 32'(err_count), v.e_errc);
        if (v.e_probe > 0)
            check({n, " probe_rgb"}, 32'(probe_rgb), v.e_prgb);
        if (v.chk_crc != 0)
            check({n, " frame_crc"}, 32'(frame_crc), v.e_crc);
        if (v.chk_xy != 0) begin
            if (log_q.size() > base) begin
                check({n, " first xy"}, 32'(log_q[base]), {12'd0, 10'd0, 10'd0});
                check({n, " last xy"}, 32'(log_q[log_q.size() - 1]),
                      {12'd0, 10'd7, 10'd3});
            end else begin
                check({n, " xy log"}, log_q.size(), base + 1);
            end
        end
    endtask

    int crc_z;
    int crc_f;

    initial begin
`ifdef VGA_MON_CRC_EN
        crc_z = int'(golden(M_ZERO));
        crc_f = int'(golden(M_FLIP));
`else
        crc_z = 0;
        crc_f = 0;
`endif
        //        mode     px py ll sl pix dn pb er lf le ec prgb       cc crc    xy rs
        tbl[0]  = '{M_CONST, 8, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,     0, 0};
        tbl[1]  = '{M_CONST, 8, 0, -1, -1, 32, 0, 0, 0, 1, 1, 0, 0,       0, 0,     0, 0};
        tbl[2]  = '{M_CONST, 8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 0, 0,       0, 0,     0, 0};
        tbl[3]  = '{M_COORD, 3, 2, -1, -1, 32, 1, 1, 0, 1, 1, 0, 'h030200, 0, 0,     1, 0};
        tbl[4]  = '{M_COORD, 8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 0, 0,       0, 0,     0, 0};
        tbl[5]  = '{M_COORD, 2, 0, 5, -1, 16, 1, 1, 1, 1, 0, 1, 'h020000,  0, 0,     0, 0};
        tbl[6]  = '{M_COORD, 8, 0, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0,        0, 0,     0, 0};
        tbl[7]  = '{M_COORD, 8, 0, -1, -1, 32, 0, 0, 0, 1, 1, 1, 0,       0, 0,     0, 0};
        tbl[8]  = '{M_COORD, 8, 0, 0, -1, 0, 1, 0, 1, 1, 0, 2, 0,         0, 0,     0, 0};
        tbl[9]  = '{M_COORD, 8, 0, -1, 3, 0, 0, 0, 0, 0, 0, 2, 0,         0, 0,     0, 0};
        tbl[10] = '{M_COORD, 8, 0, -1, -1, 0, 0, 0, 0, 0, 0, 2, 0,        0, 0,     0, 0};
        tbl[11] = '{M_COORD, 8, 0, -1, -1, 32, 0, 0, 0, 1, 1, 2, 0,       0, 0,     0, 0};
        tbl[12] = '{M_ZERO,  8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 2, 0,       0, 0,     0, 0};
        tbl[13] = '{M_ZERO,  8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 2, 0,       1, crc_z, 0, 0};
        tbl[14] = '{M_FLIP,  8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 2, 0,       1, crc_z, 0, 0};
        tbl[15] = '{M_ZERO,  8, 0, -1, -1, 32, 1, 0, 0, 1, 1, 2, 0,       1, crc_f, 0, 0};
        tbl[16] = '{M_CONST, 8, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0,     0, 1};
        tbl[17] = '{M_CONST, 8, 0, -1, -1, 32, 0, 0, 0, 1, 1, 0, 0,       0, 0,     0, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("release");

        for (int i = 0; i < 18; i++) begin
            run_rec(i, tbl[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
